// File: rtl/alu_pkg.sv
// Shared ALU package: op-code encoding, highest legal code, and the
// result-buffer state encoding used by the shared-ALU front end.
package alu_pkg;

   localparam logic [4:0] ALU_SLL  = 5'd0;
   localparam logic [4:0] ALU_SRL  = 5'd1;
   localparam logic [4:0] ALU_SRA  = 5'd2;
   localparam logic [4:0] ALU_SLLV = 5'd3;
   localparam logic [4:0] ALU_SRLV = 5'd4;
   localparam logic [4:0] ALU_SRAV = 5'd5;
   localparam logic [4:0] ALU_ADD  = 5'd6;
   localparam logic [4:0] ALU_ADDU = 5'd7;
   localparam logic [4:0] ALU_SUB  = 5'd8;
   localparam logic [4:0] ALU_SUBU = 5'd9;
   localparam logic [4:0] ALU_AND  = 5'd10;
   localparam logic [4:0] ALU_OR   = 5'd11;
   localparam logic [4:0] ALU_XOR  = 5'd12;
   localparam logic [4:0] ALU_NOR  = 5'd13;
   localparam logic [4:0] ALU_SLT  = 5'd14;
   localparam logic [4:0] ALU_SLTU = 5'd15;
   localparam logic [4:0] ALU_LUI  = 5'd16;

   // Any code above this is undefined and flagged as an error.
   localparam logic [4:0] ALU_OP_MAX = 5'd16;

   // Result buffer states.
   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU shared by both requesters.
// Undefined op codes produce zero; flagging them is the caller's job.
module alu
   import alu_pkg::*;
(
   input  logic [31:0] i_rs,
   input  logic [31:0] i_rt,
   input  logic [4:0]  i_ctrl,
   input  logic [4:0]  i_shamt,
   output logic [31:0] o_result
);

   // Variable shifts use the whole rs value, so amounts >= 32 flush out.
   always_comb begin
      o_result = 32'h0;
      case (i_ctrl)
         ALU_SLL:  o_result = i_rt << i_shamt;
         ALU_SRL:  o_result = i_rt >> i_shamt;
         ALU_SRA:  o_result = $unsigned($signed(i_rt) >>> i_shamt);
         ALU_SLLV: o_result = i_rt << i_rs;
         ALU_SRLV: o_result = i_rt >> i_rs;
         ALU_SRAV: o_result = $unsigned($signed(i_rt) >>> i_rs);
         ALU_ADD,
         ALU_ADDU: o_result = i_rs + i_rt;
         ALU_SUB,
         ALU_SUBU: o_result = i_rs - i_rt;
         ALU_AND:  o_result = i_rs & i_rt;
         ALU_OR:   o_result = i_rs | i_rt;
         ALU_XOR:  o_result = i_rs ^ i_rt;
         ALU_NOR:  o_result = ~(i_rs | i_rt);
         ALU_SLT:  o_result = {31'h0, $signed(i_rs) < $signed(i_rt)};
         ALU_SLTU: o_result = {31'h0, i_rs < i_rt};
         ALU_LUI:  o_result = {i_rt[15:0], 16'h0};
         default:  o_result = 32'h0;
      endcase
   end

endmodule

// File: rtl/alu_share_arb.sv
// Two-client round-robin front end for the shared ALU with a one-entry
// result buffer. A new op can be taken when the buffer is empty or is
// being drained by its owner in the same cycle.
module alu_share_arb
   import alu_pkg::*;
#(
   parameter logic RR_INIT = 1'b0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_rs,
   input  logic [31:0] req0_rt,
   input  logic [4:0]  req0_ctrl,
   input  logic [4:0]  req0_shamt,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_rs,
   input  logic [31:0] req1_rt,
   input  logic [4:0]  req1_ctrl,
   input  logic [4:0]  req1_shamt,
   output logic        resp0_valid,
   input  logic        resp0_ready,
   output logic        resp1_valid,
   input  logic        resp1_ready,
   output logic [31:0] resp_data,
   output logic        resp_err
);

   logic        r_state;
   logic        r_owner;
   logic        r_ptr;
   logic [31:0] r_data;
   logic        r_err;

   logic        w_drain;
   logic        w_can;
   logic        w_gnt0;
   logic        w_gnt1;
   logic [31:0] w_rs;
   logic [31:0] w_rt;
   logic [4:0]  w_ctrl;
   logic [4:0]  w_shamt;
   logic [31:0] w_result;

   // Accept when empty, or when the owner drains this cycle; hold off in reset.
   always_comb begin
      w_drain = (r_state == ST_FULL) && (r_owner ? resp1_ready : resp0_ready);
      w_can   = !rst && ((r_state == ST_EMPTY) || w_drain);
      w_gnt0  = w_can && req0_valid && (!req1_valid || (r_ptr == 1'b0));
      w_gnt1  = w_can && req1_valid && (!req0_valid || (r_ptr == 1'b1));
   end

   // Grant mux feeding the single ALU instance.
   always_comb begin
      w_rs    = w_gnt1 ? req1_rs    : req0_rs;
      w_rt    = w_gnt1 ? req1_rt    : req0_rt;
      w_ctrl  = w_gnt1 ? req1_ctrl  : req0_ctrl;
      w_shamt = w_gnt1 ? req1_shamt : req0_shamt;
   end

   alu u_alu (
      .i_rs     (w_rs),
      .i_rt     (w_rt),
      .i_ctrl   (w_ctrl),
      .i_shamt  (w_shamt),
      .o_result (w_result)
   );

   // Buffer FSM, result register and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_owner <= 1'b0;
         r_ptr   <= RR_INIT;
         r_data  <= 32'h0;
         r_err   <= 1'b0;
      end else if (w_gnt0 || w_gnt1) begin
         r_state <= ST_FULL;
         r_owner <= w_gnt1;
         r_ptr   <= w_gnt0;          // priority passes to the client not just served
         r_data  <= w_result;
         r_err   <= (w_ctrl > ALU_OP_MAX);
      end else if (w_drain) begin
         r_state <= ST_EMPTY;
      end
   end

   assign req0_ready  = w_gnt0;
   assign req1_ready  = w_gnt1;
   assign resp0_valid = (r_state == ST_FULL) && (r_owner == 1'b0);
   assign resp1_valid = (r_state == ST_FULL) && (r_owner == 1'b1);
   assign resp_data   = r_data;
   assign resp_err    = r_err;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed steps followed by random traffic, all
// compared against a transaction-level model of the arbiter and buffer.
module tb_alu_share_arb;

   localparam logic RR = 1'b0;

   logic        clk;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_rs, req0_rt, req1_rs, req1_rt;
   logic [4:0]  req0_ctrl, req0_shamt, req1_ctrl, req1_shamt;
   logic        resp0_valid, resp1_valid;
   logic        resp0_ready, resp1_ready;
   logic [31:0] resp_data;
   logic        resp_err;

   int n_chk = 0;
   int n_err = 0;

   // model state
   bit          m_full;
   bit          m_owner;
   bit          m_ptr;
   logic [31:0] m_data;
   bit          m_err;

   alu_share_arb #(.RR_INIT(RR)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_rs(req0_rs), .req0_rt(req0_rt),
      .req0_ctrl(req0_ctrl), .req0_shamt(req0_shamt),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_rs(req1_rs), .req1_rt(req1_rt),
      .req1_ctrl(req1_ctrl), .req1_shamt(req1_shamt),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_data(resp_data), .resp_err(resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_ref(input logic [4:0] c, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
      logic [31:0] r;
      r = 32'h0;
      case (c)
         5'd0:  r = b << sh;
         5'd1:  r = b >> sh;
         5'd2:  r = $unsigned($signed(b) >>> sh);
         5'd3:  r = (a >= 32) ? 32'h0 : b << a[4:0];
         5'd4:  r = (a >= 32) ? 32'h0 : b >> a[4:0];
         5'd5:  r = (a >= 32) ? {32{b[31]}} : $unsigned($signed(b) >>> a[4:0]);
         5'd6, 5'd7: r = a + b;
         5'd8, 5'd9: r = a - b;
         5'd10: r = a & b;
         5'd11: r = a | b;
         5'd12: r = a ^ b;
         5'd13: r = ~(a | b);
         5'd14: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5'd15: r = (a < b) ? 32'd1 : 32'd0;
         5'd16: r = {b[15:0], 16'h0};
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_full = 0; m_owner = 0; m_ptr = RR; m_data = 32'h0; m_err = 0;
   endtask

   task automatic set_req(input int n, input bit v, input logic [4:0] c,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
      if (n == 0) begin
         req0_valid = v; req0_ctrl = c; req0_rs = a; req0_rt = b; req0_shamt = sh;
      end else begin
         req1_valid = v; req1_ctrl = c; req1_rs = a; req1_rt = b; req1_shamt = sh;
      end
   endtask

   // One clock: check at the falling edge, advance the model at the rising edge.
   task automatic do_cycle();
      bit can, drain;
      int g;
      @(negedge clk);
      drain = m_full && (m_owner ? resp1_ready : resp0_ready);
      can   = !m_full || drain;
      g = -1;
      if (can) begin
         if (req0_valid && req1_valid) g = m_ptr;
         else if (req0_valid)          g = 0;
         else if (req1_valid)          g = 1;
      end
      chk("req0_ready", {31'h0, req0_ready}, {31'h0, g == 0});
      chk("req1_ready", {31'h0, req1_ready}, {31'h0, g == 1});
      chk("resp0_valid", {31'h0, resp0_valid}, {31'h0, m_full && !m_owner});
      chk("resp1_valid", {31'h0, resp1_valid}, {31'h0, m_full && m_owner});
      if (m_full) begin
         chk("resp_data", resp_data, m_data);
         chk("resp_err", {31'h0, resp_err}, {31'h0, m_err});
      end
      @(posedge clk);
      if (g == 0) begin
         m_data = alu_ref(req0_ctrl, req0_rs, req0_rt, req0_shamt);
         m_err = req0_ctrl > 5'd16; m_full = 1; m_owner = 0; m_ptr = 1;
      end else if (g == 1) begin
         m_data = alu_ref(req1_ctrl, req1_rs, req1_rt, req1_shamt);
         m_err = req1_ctrl > 5'd16; m_full = 1; m_owner = 1; m_ptr = 0;
      end else if (drain) begin
         m_full = 0;
      end
      #1;
   endtask

   initial begin
      rst = 1'b1;
      set_req(0, 0, 5'd0, 32'h0, 32'h0, 5'd0);
      set_req(1, 0, 5'd0, 32'h0, 32'h0, 5'd0);
      resp0_ready = 1'b0; resp1_ready = 1'b0;
      model_reset();
      #3;
      chk("rst_resp0_valid", {31'h0, resp0_valid}, 32'h0);
      chk("rst_resp1_valid", {31'h0, resp1_valid}, 32'h0);
      chk("rst_data", resp_data, 32'h0);
      chk("rst_err", {31'h0, resp_err}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // single request
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      set_req(0, 1, 5'd6, 32'd3, 32'd4, 5'd0);
      do_cycle();
      chk("add_data", resp_data, 32'd7);
      chk("add_resp1_valid", {31'h0, resp1_valid}, 32'h0);
      set_req(0, 0, 5'd0, 32'h0, 32'h0, 5'd0);
      do_cycle();

      // contention: alternating grants
      for (int i = 0; i < 6; i++) begin
         set_req(0, 1, 5'd6, 32'(i), 32'd100, 5'd0);
         set_req(1, 1, 5'd8, 32'd1000, 32'(i), 5'd0);
         do_cycle();
      end
      set_req(0, 0, 5'd0, 32'h0, 32'h0, 5'd0);
      set_req(1, 0, 5'd0, 32'h0, 32'h0, 5'd0);
      do_cycle();

      // backpressure on client 0
      set_req(0, 1, 5'd12, 32'hA5A5_0000, 32'h0000_5A5A, 5'd0);
      do_cycle();
      resp0_ready = 1'b0;
      set_req(1, 1, 5'd7, 32'd20, 32'd22, 5'd0);
      for (int i = 0; i < 3; i++) do_cycle();
      chk("bp_data_held", resp_data, 32'hA5A5_5A5A);
      resp0_ready = 1'b1;
      do_cycle();
      set_req(0, 0, 5'd0, 32'h0, 32'h0, 5'd0);
      set_req(1, 0, 5'd0, 32'h0, 32'h0, 5'd0);
      do_cycle();

      // op coverage via client 1
      set_req(1, 1, 5'd2, 32'h0, 32'hFFFF_FFF8, 5'd1);
      do_cycle();
      chk("sra", resp_data, 32'hFFFF_FFFC);
      set_req(1, 1, 5'd14, 32'hFFFF_FFFF, 32'd1, 5'd0);
      do_cycle();
      chk("slt", resp_data, 32'd1);
      set_req(1, 1, 5'd15, 32'hFFFF_FFFF, 32'd1, 5'd0);
      do_cycle();
      chk("sltu", resp_data, 32'd0);
      set_req(1, 1, 5'd16, 32'h0, 32'h0000_1234, 5'd0);
      do_cycle();
      chk("lui", resp_data, 32'h1234_0000);
      set_req(1, 0, 5'd0, 32'h0, 32'h0, 5'd0);

      // illegal op on client 0
      set_req(0, 1, 5'd31, 32'd9, 32'd9, 5'd0);
      do_cycle();
      chk("illegal_data", resp_data, 32'h0);
      chk("illegal_err", {31'h0, resp_err}, 32'd1);
      set_req(0, 0, 5'd0, 32'h0, 32'h0, 5'd0);
      do_cycle();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         set_req(0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 20)),
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                 $urandom, 5'($urandom));
         set_req(1, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 20)),
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                 $urandom, 5'($urandom));
         resp0_ready = $urandom_range(0, 2) != 0;
         resp1_ready = $urandom_range(0, 2) != 0;
         do_cycle();
      end

      // async reset while client 1 holds a result
      set_req(0, 0, 5'd0, 32'h0, 32'h0, 5'd0);
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      do_cycle();
      set_req(1, 1, 5'd31, 32'd1, 32'd2, 5'd0);
      do_cycle();
      chk("pre_rst_resp1_valid", {31'h0, resp1_valid}, 32'd1);
      set_req(1, 0, 5'd0, 32'h0, 32'h0, 5'd0);
      set_req(0, 1, 5'd6, 32'd1, 32'd1, 5'd0);
      resp1_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_resp1_valid", {31'h0, resp1_valid}, 32'h0);
      chk("mid_rst_data", resp_data, 32'h0);
      chk("mid_rst_err", {31'h0, resp_err}, 32'h0);
      chk("mid_rst_req0_ready", {31'h0, req0_ready}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      set_req(0, 1, 5'd6, 32'd5, 32'd6, 5'd0);
      set_req(1, 1, 5'd6, 32'd7, 32'd8, 5'd0);
      do_cycle();
      chk("post_rst_owner0", {31'h0, resp0_valid}, 32'd1);
      chk("post_rst_data", resp_data, 32'd11);
      set_req(0, 0, 5'd0, 32'h0, 32'h0, 5'd0);
      set_req(1, 0, 5'd0, 32'h0, 32'h0, 5'd0);
      do_cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester front end for the shared 32-bit integer ALU. Two independent clients (e.g. main pipeline EX stage and address/branch helper) each issue operations over a valid/ready handshake. A round-robin arbiter grants one per cycle, the ALU evaluates it, and the result is buffered in a one-entry output register until the owning client accepts it.

## Interface
Parameters:
- RR_INIT, 0: requester holding priority after reset (0 or 1).

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- reqN_valid  in  1  request from client N (N = 0, 1).
- reqN_ready  out  1  request accepted this cycle (handshake = valid & ready).
- reqN_rs  in  32  first operand.
- reqN_rt  in  32  second operand.
- reqN_ctrl  in  5  ALU operation code (shared package encoding).
- reqN_shamt  in  5  shift amount for immediate shifts.
- respN_valid  out  1  result for client N is pending.
- respN_ready  in  1  client N accepts the result (handshake = valid & ready).
- resp_data  out  32  result value, meaningful with either respN_valid.
- resp_err  out  1  pending op code was undefined (> 5'd16); resp_data is 0.

## Operation
- Result buffer FSM: EMPTY, FULL(owner). Reset goes to EMPTY.
- can_accept = EMPTY, or FULL with owner's respN_ready = 1 (drain and refill in the same cycle).
- Arbitration, when can_accept: one valid -> grant it. Both valid -> grant the priority holder. Neither -> no grant.
- reqN_ready = grant to N. Combinational from the valids, the priority pointer and the buffer state. Never asserted while FULL and not draining.
- Priority pointer moves to the other requester only on a completed request handshake. It is unchanged on idle or stalled cycles.
- On handshake, the granted fields drive the internal ALU. At the clock edge: buffer <- {alu result, owner = N, err = ctrl > 16}, state FULL.
- FULL, owner drains, no new grant -> EMPTY.
- FULL, owner not ready -> hold. resp_data, resp_err and respN_valid stay stable.
- respN_valid = FULL & owner == N. The other client's resp valid is 0.
- Requester rule: fields stay stable while valid & !ready. The block does not check this.
- Arithmetic is exactly the ALU's:
  - add and sub wrap mod 2^32; no overflow trap.
  - slt is signed, sltu unsigned.
  - Variable shifts use the full rs value, so rs >= 32 yields 0 (sign fill for srav).
  - lui = {rt[15:0], 16'h0}.
  - Undefined codes yield 0, and resp_err = 1.

## Timing
- Reset values, asserted asynchronously and immediately:
  - reqN_ready = 0 while rst is high.
  - respN_valid = 0, resp_data = 0, resp_err = 0.
  - State EMPTY; priority pointer = RR_INIT.
- Latency: handshake in cycle T -> respN_valid high in cycle T+1.
- Throughput: 1 op/cycle sustained when the owner holds respN_ready = 1.
- No combinational path from respN_ready to resp_data. The path respN_ready -> reqM_ready is allowed.
- Reset mid-operation discards the pending result and any in-flight grant. No response is ever produced for it.
- rst deassertion synchronous to clk is the integrator's duty. First grant is possible in the first cycle with rst low.

## Structure
- Shared package alu_pkg:
  - ALU op-code constants: sll 0, srl 1, sra 2, sllv 3, srlv 4, srav 5, add 6, addu 7, sub 8, subu 9, and 10, or 11, xor 12, nor 13, slt 14, sltu 15, lui 16.
  - Constant for the highest legal code (16).
  - FSM state encoding.
- One sub-module: the existing combinational alu, instantiated once and fed by the grant mux.
- This block contains only the mux, arbiter, pointer, FSM and result register.

## Test plan
- Single request: req0 add, rs=3, rt=4 -> req0_ready=1 the same cycle. Next cycle resp0_valid=1, resp_data=7, resp_err=0, resp1_valid=0.
- Contention, RR_INIT=0: both valid every cycle, both resp_ready=1 -> grants 0,1,0,1,... One result per cycle, each on the correct respN_valid.
- Backpressure: resp0 pending with resp0_ready=0 for 3 cycles, both reqs valid:
  - Both req_ready stay 0 and resp_data is stable.
  - Raise resp0_ready -> same cycle grants the priority holder; its result appears next cycle.
- Op coverage via req1:
  - sra rt=0xFFFFFFF8, shamt=1 -> 0xFFFFFFFC.
  - slt rs=0xFFFFFFFF, rt=1 -> 1; sltu same operands -> 0.
  - lui rt=0x1234 -> 0x12340000.
- Illegal op: req0 ctrl=5'b11111 -> resp_data=0, resp_err=1, handshake completes normally.
- Async reset mid-op: assert rst between clock edges while resp1_valid=1:
  - resp1_valid, resp_data and resp_err go to 0 immediately.
  - After release, the first contended grant goes to RR_INIT.
